// File: rtl/cache_mem_arbiter_pkg.sv
//----------------------------------------------------------------------------
// cache_mem_arbiter_pkg
//   Line-width constants shared with the L1 caches and the arbiter state
//   encoding used by cache_mem_arbiter.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

package cache_mem_arbiter_pkg;

  localparam int unsigned CACHE_LINE_W = 256;
  localparam int unsigned CACHE_ADDR_W = 32;

  typedef logic [2:0] arb_state_t;

  localparam arb_state_t ST_IDLE    = 3'd0;
  localparam arb_state_t ST_SERVE_I = 3'd1;
  localparam arb_state_t ST_SERVE_D = 3'd2;
  localparam arb_state_t ST_DONE_I  = 3'd3;
  localparam arb_state_t ST_DONE_D  = 3'd4;

  // Number of byte-offset bits inside one cache line.
  function automatic int unsigned line_offset_bits(input int unsigned line_w);
    return $clog2(line_w / 8);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cache_mem_arbiter_if.sv
//----------------------------------------------------------------------------
// cache_mem_arbiter_if
//   I-cache, D-cache and memory line-port signals around the arbiter.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

interface cache_mem_arbiter_if
  import cache_mem_arbiter_pkg::*;
#(
  parameter int LINE_W = CACHE_LINE_W,
  parameter int ADDR_W = CACHE_ADDR_W
) ();

  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  // Arbiter side.
  modport slave (
    input  i_read, i_addr,
    output i_rdata, i_resp,
    input  d_read, d_write, d_addr, d_wdata,
    output d_rdata, d_resp,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_resp
  );

  // Caches and memory side.
  modport master (
    output i_read, i_addr,
    input  i_rdata, i_resp,
    output d_read, d_write, d_addr, d_wdata,
    input  d_rdata, d_resp,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_resp
  );

endinterface

`default_nettype wire

// File: rtl/cache_mem_arbiter_grant_sel.sv
//----------------------------------------------------------------------------
// arb_grant_sel
//   Combinational tie-break between I and D line requests. The pointer
//   (1 = prefer D) is only honoured when ARB_ROUND_ROBIN_EN is defined.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module arb_grant_sel
  import cache_mem_arbiter_pkg::*;
(
  input  wire logic i_req_i,
  input  wire logic i_req_d,
  input  wire logic i_ptr_d,
  output logic      o_grant_i,
  output logic      o_grant_d
);

`ifdef ARB_ROUND_ROBIN_EN
  assign o_grant_d = i_req_d & (~i_req_i |  i_ptr_d);
  assign o_grant_i = i_req_i & (~i_req_d | ~i_ptr_d);
`else
  // D is the older pipeline stage, so it always wins a tie.
  assign o_grant_d = i_req_d;
  assign o_grant_i = i_req_i & ~i_req_d;

  logic unused_ptr;
  assign unused_ptr = i_ptr_d;
`endif

endmodule

`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
//----------------------------------------------------------------------------
// cache_mem_arbiter
//   Shares one memory line port between I-cache fills and D-cache
//   fills/writebacks. Optional macro ARB_ROUND_ROBIN_EN alternates tie-breaks.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int LINE_W = CACHE_LINE_W,
  parameter int ADDR_W = CACHE_ADDR_W
) (
  input  wire logic           clk,
  input  wire logic           rst,
  cache_mem_arbiter_if.slave  bus
);

  localparam int unsigned OFF_W = line_offset_bits(LINE_W);

  arb_state_t        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic              r_is_write;
  logic [LINE_W-1:0] r_i_rdata;
  logic [LINE_W-1:0] r_d_rdata;

  logic              w_i_req;
  logic              w_d_req;
  logic              w_grant_i;
  logic              w_grant_d;
  logic              w_ptr_d;
  logic [ADDR_W-1:0] w_i_line;
  logic [ADDR_W-1:0] w_d_line;

  assign w_i_req  = bus.i_read;
  assign w_d_req  = bus.d_read | bus.d_write;
  assign w_i_line = {bus.i_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign w_d_line = {bus.d_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{bus.i_addr[OFF_W-1:0], bus.d_addr[OFF_W-1:0]};

`ifdef ARB_ROUND_ROBIN_EN
  logic r_ptr_d;

  // After each grant the preference moves to the side that was not served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr_d <= 1'b1;
    end else if (r_state == ST_IDLE) begin
      if (w_grant_d) begin
        r_ptr_d <= 1'b0;
      end else if (w_grant_i) begin
        r_ptr_d <= 1'b1;
      end
    end
  end

  assign w_ptr_d = r_ptr_d;
`else
  assign w_ptr_d = 1'b1;
`endif

  arb_grant_sel u_grant_sel (
    .i_req_i   (w_i_req),
    .i_req_d   (w_d_req),
    .i_ptr_d   (w_ptr_d),
    .o_grant_i (w_grant_i),
    .o_grant_d (w_grant_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_is_write <= 1'b0;
      r_i_rdata  <= '0;
      r_d_rdata  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_d) begin
            r_state    <= ST_SERVE_D;
            r_addr     <= w_d_line;
            // A simultaneous read+write is handled as a writeback.
            r_is_write <= bus.d_write;
            r_wdata    <= bus.d_write ? bus.d_wdata : '0;
          end else if (w_grant_i) begin
            r_state    <= ST_SERVE_I;
            r_addr     <= w_i_line;
            r_is_write <= 1'b0;
            r_wdata    <= '0;
          end
        end
        ST_SERVE_I: begin
          if (bus.mem_resp) begin
            r_i_rdata <= bus.mem_rdata;
            r_state   <= ST_DONE_I;
          end
        end
        ST_SERVE_D: begin
          if (bus.mem_resp) begin
            if (!r_is_write) begin
              r_d_rdata <= bus.mem_rdata;
            end
            r_state <= ST_DONE_D;
          end
        end
        ST_DONE_I,
        ST_DONE_D: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Strobes decode straight from state so reset removes them immediately.
  assign bus.mem_read  = (r_state == ST_SERVE_I) |
                         ((r_state == ST_SERVE_D) & ~r_is_write);
  assign bus.mem_write = (r_state == ST_SERVE_D) & r_is_write;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;

  assign bus.i_resp  = (r_state == ST_DONE_I);
  assign bus.d_resp  = (r_state == ST_DONE_D);
  assign bus.i_rdata = r_i_rdata;
  assign bus.d_rdata = r_d_rdata;

`ifndef SYNTHESIS
  a_d_read_write_exclusive: assert property (
    @(posedge clk) disable iff (rst) !(bus.d_read && bus.d_write));

  a_mem_strobe_exclusive: assert property (
    @(posedge clk) disable iff (rst) !(bus.mem_read && bus.mem_write));
`endif

endmodule

`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
//----------------------------------------------------------------------------
// tb_cache_mem_arbiter
//   Directed vector table plus hand sequences for cache_mem_arbiter.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_cache_mem_arbiter;
  import cache_mem_arbiter_pkg::*;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cache_mem_arbiter_if #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) bus ();

  cache_mem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  int              mem_lat   = 5;
  int              mem_cnt   = 0;
  int              n_mem_wr  = 0;
  logic [31:0]     wr_addr_q = '0;
  logic [255:0]    wr_data_q = '0;

  function automatic logic [255:0] mem_line(input logic [31:0] a);
    if (a == 32'h0000_1040) return {32{8'hAA}};
    return {8{a ^ 32'h5A5A_0000}};
  endfunction

  always @(posedge clk) begin
    bus.mem_resp  <= 1'b0;
    bus.mem_rdata <= {8{32'hDEAD_BEEF}};
    if (rst) begin
      mem_cnt <= 0;
    end else if ((bus.mem_read || bus.mem_write) && !bus.mem_resp) begin
      if (mem_cnt >= mem_lat) begin
        bus.mem_resp <= 1'b1;
        mem_cnt      <= 0;
        if (bus.mem_write) begin
          wr_addr_q <= bus.mem_addr;
          wr_data_q <= bus.mem_wdata;
          n_mem_wr  <= n_mem_wr + 1;
        end else begin
          bus.mem_rdata <= mem_line(bus.mem_addr);
        end
      end else begin
        mem_cnt <= mem_cnt + 1;
      end
    end
  end

  // ---------------- monitor ----------------
  int           n_iresp = 0;
  int           n_dresp = 0;
  int           order_q[$];
  logic         strb_prev = 1'b0;
  logic [31:0]  addr_s = '0;
  logic [255:0] wdata_s = '0;
`ifdef ARB_ROUND_ROBIN_EN
  bit           pref_d = 1'b1;
`endif

  always @(negedge clk) begin
    if (rst) begin
      strb_prev = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      pref_d = 1'b1;
`endif
    end else begin
      check("strobe_exclusive", 256'(bus.mem_read & bus.mem_write), 256'(0));
      check("resp_exclusive", 256'(bus.i_resp & bus.d_resp), 256'(0));
      if (bus.i_resp) begin
        n_iresp++;
        order_q.push_back(0);
`ifdef ARB_ROUND_ROBIN_EN
        pref_d = 1'b1;
`endif
      end
      if (bus.d_resp) begin
        n_dresp++;
        order_q.push_back(1);
`ifdef ARB_ROUND_ROBIN_EN
        pref_d = 1'b0;
`endif
      end
      if (bus.mem_read || bus.mem_write) begin
        if (strb_prev) begin
          check("mem_addr_stable", 256'(bus.mem_addr), 256'(addr_s));
          check("mem_wdata_stable", bus.mem_wdata, wdata_s);
        end else begin
          addr_s  = bus.mem_addr;
          wdata_s = bus.mem_wdata;
        end
        strb_prev = 1'b1;
      end else begin
        strb_prev = 1'b0;
      end
    end
  end

  // ---------------- requesters ----------------
  task automatic req_i(input logic [31:0] a, output int lat, output logic [255:0] data);
    bit got;
    got  = 1'b0;
    lat  = 0;
    data = '0;
    @(negedge clk);
    bus.i_read = 1'b1;
    bus.i_addr = a;
    while (!got && lat < 300) begin
      @(negedge clk);
      lat++;
      if (bus.i_resp) begin
        got  = 1'b1;
        data = bus.i_rdata;
      end
    end
    check("i_resp_seen", 256'(got), 256'(1));
    if (got) @(negedge clk);
    bus.i_read = 1'b0;
  endtask

  task automatic req_d(input bit wr, input logic [31:0] a, input logic [255:0] wd,
                       input bit scramble, output int lat, output logic [255:0] data);
    bit got;
    got  = 1'b0;
    lat  = 0;
    data = '0;
    @(negedge clk);
    bus.d_read  = ~wr;
    bus.d_write = wr;
    bus.d_addr  = a;
    bus.d_wdata = wd;
    while (!got && lat < 300) begin
      @(negedge clk);
      lat++;
      if (scramble && lat == 2) bus.d_wdata = ~wd;
      if (bus.d_resp) begin
        got  = 1'b1;
        data = bus.d_rdata;
      end
    end
    check("d_resp_seen", 256'(got), 256'(1));
    if (got) @(negedge clk);
    bus.d_read  = 1'b0;
    bus.d_write = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit           i_en;
    bit           d_en;
    bit           d_wr;
    bit           tie;
    int           i_dly;
    int           d_dly;
    logic [31:0]  i_addr;
    logic [31:0]  d_addr;
    logic [255:0] d_wdata;
    int           exp_first;   // 0 = I, 1 = D
  } vec_t;

  vec_t vecs[8];

  initial begin
    vec_t         cur;
    int           lat_i, lat_d, exp_first, nw0, ni0, nd0, exp_i_cnt, exp_d_cnt;
    logic [255:0] dat_i, dat_d;
    logic [31:0]  ra_i, ra_d;
    logic [255:0] rwd;
    bit           r_ien, r_den, r_wr;
    int           r_idly, r_ddly;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0000_3000, 32'h0000_0000, '0, 0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 32'h0000_0000, 32'h0000_5020, '0, 1};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 32'h0000_0000, 32'h0000_2000, {8{32'h1234_5678}}, 1};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 0, 0, 32'h0000_4000, 32'h0000_5000, '0, 1};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 32'h0000_4100, 32'h0000_6000, {8{32'hCAFE_F00D}}, 1};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 2, 32'h0000_7000, 32'h0000_7100, '0, 0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 2, 0, 32'h0000_8100, 32'h0000_8000, '0, 1};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 0, 0, 32'h0000_901F, 32'h0000_A03C, '0, 1};

    bus.i_read  = 1'b0;
    bus.i_addr  = '0;
    bus.d_read  = 1'b0;
    bus.d_write = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_mem_read",  256'(bus.mem_read),  256'(0));
    check("rst_mem_write", 256'(bus.mem_write), 256'(0));
    check("rst_mem_addr",  256'(bus.mem_addr),  256'(0));
    check("rst_mem_wdata", bus.mem_wdata, '0);
    check("rst_i_resp",    256'(bus.i_resp),    256'(0));
    check("rst_d_resp",    256'(bus.d_resp),    256'(0));
    check("rst_i_rdata",   bus.i_rdata, '0);
    check("rst_d_rdata",   bus.d_rdata, '0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Sequence A: I-only read, latency and strobe timing
    mem_lat = 5;
    ni0 = n_iresp;
    nd0 = n_dresp;
    fork
      req_i(32'h0000_1040, lat_i, dat_i);
      begin
        @(negedge clk);
        check("seqA_strobe_c0", 256'(bus.mem_read), 256'(0));
        @(negedge clk);
        check("seqA_mem_read_c1",  256'(bus.mem_read),  256'(1));
        check("seqA_mem_write_c1", 256'(bus.mem_write), 256'(0));
        check("seqA_mem_addr_c1",  256'(bus.mem_addr),  256'(32'h0000_1040));
      end
    join
    check("seqA_latency", 256'(lat_i), 256'(8));
    check("seqA_i_rdata", dat_i, {32{8'hAA}});
    check("seqA_i_resp_count", 256'(n_iresp - ni0), 256'(1));
    check("seqA_no_d_resp", 256'(n_dresp - nd0), 256'(0));

    // Sequence B: D writeback with d_wdata changed mid-transaction
    nw0 = n_mem_wr;
    nd0 = n_dresp;
    req_d(1'b1, 32'h0000_2000, {8{32'h1234_5678}}, 1'b1, lat_d, dat_d);
    check("seqB_wr_count", 256'(n_mem_wr - nw0), 256'(1));
    check("seqB_wr_addr",  256'(wr_addr_q), 256'(32'h0000_2000));
    check("seqB_wr_data",  wr_data_q, {8{32'h1234_5678}});
    check("seqB_d_resp_count", 256'(n_dresp - nd0), 256'(1));
    bus.d_wdata = '0;
    @(negedge clk);

    // Table vectors
    for (int k = 0; k < 8; k++) begin
      cur = vecs[k];
      exp_first = cur.exp_first;
`ifdef ARB_ROUND_ROBIN_EN
      if (cur.tie) exp_first = pref_d ? 1 : 0;
`endif
      order_q.delete();
      nw0 = n_mem_wr;
      fork
        begin
          if (cur.i_en) begin
            repeat (cur.i_dly) @(negedge clk);
            req_i(cur.i_addr, lat_i, dat_i);
          end
        end
        begin
          if (cur.d_en) begin
            repeat (cur.d_dly) @(negedge clk);
            req_d(cur.d_wr, cur.d_addr, cur.d_wdata, 1'b0, lat_d, dat_d);
          end
        end
      join
      check($sformatf("v%0d_order_len", k), 256'(order_q.size()), 256'(int'(cur.i_en) + int'(cur.d_en)));
      if (order_q.size() > 0)
        check($sformatf("v%0d_first", k), 256'(order_q[0]), 256'(exp_first));
      if (cur.i_en)
        check($sformatf("v%0d_i_rdata", k), dat_i, mem_line(cur.i_addr & 32'hFFFF_FFE0));
      if (cur.d_en && !cur.d_wr)
        check($sformatf("v%0d_d_rdata", k), dat_d, mem_line(cur.d_addr & 32'hFFFF_FFE0));
      if (cur.d_en && cur.d_wr) begin
        check($sformatf("v%0d_wr_count", k), 256'(n_mem_wr - nw0), 256'(1));
        check($sformatf("v%0d_wr_addr", k), 256'(wr_addr_q), 256'(cur.d_addr & 32'hFFFF_FFE0));
        check($sformatf("v%0d_wr_data", k), wr_data_q, cur.d_wdata);
      end
      if (cur.i_en && !cur.d_en) check($sformatf("v%0d_i_lat", k), 256'(lat_i), 256'(mem_lat + 3));
      if (cur.d_en && !cur.i_en) check($sformatf("v%0d_d_lat", k), 256'(lat_d), 256'(mem_lat + 3));
    end

    // Sequence C: D re-requests after each resp while I is held
    order_q.delete();
    fork
      req_i(32'h0000_B000, lat_i, dat_i);
      begin
        req_d(1'b0, 32'h0000_C000, '0, 1'b0, lat_d, dat_d);
        req_d(1'b0, 32'h0000_C040, '0, 1'b0, lat_d, dat_d);
      end
    join
    check("seqC_len", 256'(order_q.size()), 256'(3));
    if (order_q.size() == 3) begin
      check("seqC_0", 256'(order_q[0]), 256'(1));
      check("seqC_1", 256'(order_q[1]), 256'(0));
      check("seqC_2", 256'(order_q[2]), 256'(1));
    end
    check("seqC_i_rdata", dat_i, mem_line(32'h0000_B000));
    check("seqC_d_rdata", dat_d, mem_line(32'h0000_C040));

    // Sequence D: reset during SERVE_I
    ni0 = n_iresp;
    @(negedge clk);
    bus.i_read = 1'b1;
    bus.i_addr = 32'h0000_D000;
    repeat (2) @(negedge clk);
    check("seqD_mem_read_before", 256'(bus.mem_read), 256'(1));
    #2 rst = 1'b1;
    #1;
    check("seqD_mem_read_async", 256'(bus.mem_read), 256'(0));
    check("seqD_mem_write_async", 256'(bus.mem_write), 256'(0));
    check("seqD_i_resp", 256'(bus.i_resp), 256'(0));
    check("seqD_d_resp", 256'(bus.d_resp), 256'(0));
    check("seqD_state_idle", 256'(dut.r_state), 256'(ST_IDLE));
    @(negedge clk);
    bus.i_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    req_d(1'b0, 32'h0000_E000, '0, 1'b0, lat_d, dat_d);
    check("seqD_d_after_rst_lat", 256'(lat_d), 256'(mem_lat + 3));
    check("seqD_d_after_rst_data", dat_d, mem_line(32'h0000_E000));
    check("seqD_no_i_resp", 256'(n_iresp - ni0), 256'(0));

    // Random traffic: every request gets exactly one resp
    ni0 = n_iresp;
    nd0 = n_dresp;
    exp_i_cnt = 0;
    exp_d_cnt = 0;
    for (int r = 0; r < 1000; r++) begin
      mem_lat = $urandom_range(0, 2);
      r_ien   = 1'($urandom_range(0, 1));
      r_den   = r_ien ? 1'($urandom_range(0, 1)) : 1'b1;
      r_wr    = 1'($urandom_range(0, 1));
      r_idly  = $urandom_range(0, 3);
      r_ddly  = $urandom_range(0, 3);
      ra_i    = $urandom() & 32'hFFFF_FFE0;
      ra_d    = $urandom() & 32'hFFFF_FFE0;
      rwd     = {8{$urandom()}};
      fork
        begin
          if (r_ien) begin
            repeat (r_idly) @(negedge clk);
            req_i(ra_i, lat_i, dat_i);
          end
        end
        begin
          if (r_den) begin
            repeat (r_ddly) @(negedge clk);
            req_d(r_wr, ra_d, rwd, 1'b0, lat_d, dat_d);
          end
        end
      join
      if (r_ien) begin
        exp_i_cnt++;
        check("rnd_i_rdata", dat_i, mem_line(ra_i));
      end
      if (r_den) begin
        exp_d_cnt++;
        if (r_wr) check("rnd_wr_data", wr_data_q, rwd);
        else      check("rnd_d_rdata", dat_d, mem_line(ra_d));
      end
    end
    repeat (3) @(negedge clk);
    check("rnd_i_resp_total", 256'(n_iresp - ni0), 256'(exp_i_cnt));
    check("rnd_d_resp_total", 256'(n_dresp - nd0), 256'(exp_d_cnt));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
